// File: rtl/motor_ctrl_pkg.sv
// motor_ctrl_pkg: shared motor-control defaults, FSM state type and duty helper
package motor_ctrl_pkg;

    localparam int DEF_PERIOD      = 5000;
    localparam int DEF_DUTY_MAX    = 4000;
    localparam int DEF_DEAD_CYCLES = 200;

    typedef enum logic [1:0] {IDLE, RUN, DEADTIME, RESYNC} motor_state_t;

    // 17-bit magnitude so that -32768 maps to 32768 without overflow
    function automatic logic [16:0] cmd_abs(input logic signed [15:0] c);
        logic signed [16:0] e;
        e = {c[15], c};
        return e[16] ? -e : e;
    endfunction

endpackage

// File: rtl/pwm_hbridge_driver_if.sv
// pwm_hbridge_driver_if: command and gate-drive signals of the H-bridge PWM driver
interface pwm_hbridge_driver_if;
    logic               enable;
    logic signed [15:0] control_signal;
    logic               pwm_out;
    logic               dir_out;
    logic               period_start;
    logic               deadtime_active;

    modport master (
        output enable, control_signal,
        input  pwm_out, dir_out, period_start, deadtime_active
    );

    modport slave (
        input  enable, control_signal,
        output pwm_out, dir_out, period_start, deadtime_active
    );
endinterface

// File: rtl/pwm_period_counter.sv
// pwm_period_counter: free-running 0..PERIOD-1 counter with wrap flag and registered period_start
module pwm_period_counter #(
    parameter int PERIOD = 5000,
    parameter int CW     = $clog2(PERIOD)
) (
    input  logic          clk,
    input  logic          reset_n,
    output logic [CW-1:0] cnt,
    output logic          wrap,
    output logic          period_start
);

    assign wrap = cnt == CW'(PERIOD - 1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt          <= '0;
            period_start <= 1'b0;
        end else begin
            cnt          <= wrap ? '0 : cnt + 1'b1;
            period_start <= cnt == '0;
        end
    end

endmodule

// File: rtl/pwm_hbridge_driver.sv
// pwm_hbridge_driver: sign/magnitude PWM for an H-bridge with dead-time on direction reversal
module pwm_hbridge_driver
    import motor_ctrl_pkg::*;
#(
    parameter int PERIOD      = DEF_PERIOD,
    parameter int DUTY_MAX    = DEF_DUTY_MAX,
    parameter int DEAD_CYCLES = DEF_DEAD_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    pwm_hbridge_driver_if.slave bus
);

    localparam int CW  = $clog2(PERIOD);
    localparam int DTW = $clog2(DEAD_CYCLES + 1);

    motor_state_t   state, next;
    logic [CW-1:0]  cnt;
    logic           wrap;
    logic [16:0]    cmd_mag;
    logic [15:0]    sample_duty;
    logic [15:0]    duty;
    logic [DTW-1:0] dt_cnt;
    logic           dt_done;
    logic           req_dir;
    logic           reversal;
    logic           pwm;
    logic           dir;

    pwm_period_counter #(.PERIOD(PERIOD), .CW(CW)) u_counter (
        .clk          (clk),
        .reset_n      (reset_n),
        .cnt          (cnt),
        .wrap         (wrap),
        .period_start (bus.period_start)
    );

    assign cmd_mag     = cmd_abs(bus.control_signal);
    assign sample_duty = cmd_mag > 17'(DUTY_MAX) ? 16'(DUTY_MAX) : cmd_mag[15:0];
    assign req_dir     = !bus.control_signal[15];
    assign reversal    = (bus.control_signal != '0) && (req_dir != dir);
    assign dt_done     = dt_cnt == DTW'(DEAD_CYCLES - 1);

    // A reversal is also checked when leaving IDLE so the bridge never drives the stale direction
    always_comb begin
        next = state;
        case (state)
            IDLE, RESYNC: next = wrap ? (reversal ? DEADTIME : RUN) : state;
            RUN:          next = (wrap && reversal) ? DEADTIME : RUN;
            DEADTIME:     next = dt_done ? RESYNC : DEADTIME;
            default:      next = IDLE;
        endcase
        if (!bus.enable) next = IDLE;
    end

    // The shadow sample is taken on the wrap cycle and becomes the active duty at that same edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            duty   <= '0;
            dt_cnt <= '0;
            pwm    <= 1'b0;
            dir    <= 1'b1;
        end else begin
            state  <= next;
            duty   <= wrap ? sample_duty : duty;
            dt_cnt <= state == DEADTIME ? dt_cnt + 1'b1 : '0;
            pwm    <= bus.enable && state == RUN && 32'(cnt) < 32'(duty);
            dir    <= (state == DEADTIME && next == RESYNC) ? !dir : dir;
        end
    end

    assign bus.pwm_out         = pwm;
    assign bus.dir_out         = dir;
    assign bus.deadtime_active = state == DEADTIME;

endmodule

// File: tb/tb_pwm_hbridge_driver.sv
// tb_pwm_hbridge_driver: directed per-period checks of the H-bridge PWM driver
module tb_pwm_hbridge_driver;

    localparam int PERIOD = 5000;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad = 0;
    int   hi, dtn, dt_first, dir_chg, ps_n, ps_at, dir_end, n;

    pwm_hbridge_driver_if bus();

    pwm_hbridge_driver dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sync(output int waited);
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!bus.period_start && waited < 2 * PERIOD);
        if (!bus.period_start) check("sync_timeout", 0, 1);
        repeat (PERIOD - 1) @(negedge clk);
    endtask

    task automatic win(input int chg_at, input int chg_val, input int off_at, input int on_at);
        logic d0;
        hi = 0; dtn = 0; dt_first = -1; dir_chg = -1; ps_n = 0; ps_at = -1;
        d0 = bus.dir_out;
        for (int i = 0; i < PERIOD; i++) begin
            if (i == chg_at) bus.control_signal = 16'(chg_val);
            if (i == off_at) bus.enable = 1'b0;
            if (i == on_at) bus.enable = 1'b1;
            hi += int'(bus.pwm_out);
            if (bus.deadtime_active) begin
                if (dt_first < 0) dt_first = i;
                dtn++;
            end
            if (bus.period_start) begin
                if (ps_at < 0) ps_at = i;
                ps_n++;
            end
            if (bus.dir_out != d0 && dir_chg < 0) dir_chg = i;
            dir_end = int'(bus.dir_out);
            @(negedge clk);
        end
    endtask

    task automatic expect_win(input string tag, input int e_hi, input int e_dt, input int e_dchg, input int e_dir);
        check({tag, ".high"}, hi, e_hi);
        check({tag, ".dead"}, dtn, e_dt);
        check({tag, ".dead_first"}, dt_first, e_dt > 0 ? 0 : -1);
        check({tag, ".dir_change"}, dir_chg, e_dchg);
        check({tag, ".dir"}, dir_end, e_dir);
        check({tag, ".ps_count"}, ps_n, 1);
        check({tag, ".ps_at"}, ps_at, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".pwm"}, int'(bus.pwm_out), 0);
        check({tag, ".dir"}, int'(bus.dir_out), 1);
        check({tag, ".ps"}, int'(bus.period_start), 0);
        check({tag, ".dead"}, int'(bus.deadtime_active), 0);
    endtask

    initial begin
        reset_n = 1'b0;
        bus.enable = 1'b0;
        bus.control_signal = '0;
        repeat (5) @(negedge clk);
        check_reset("reset");
        reset_n = 1'b1;
        bus.enable = 1'b1;
        bus.control_signal = 16'sd2500;
        sync(n);
        check("restart_ps", n, 1);
        win(10, 1000, -1, -1);      expect_win("t1_2500", 2500, 0, -1, 1);
        win(2000, 3000, -1, -1);    expect_win("t4_1000", 1000, 0, -1, 1);
        win(10, 6000, -1, -1);      expect_win("t4_3000", 3000, 0, -1, 1);
        win(10, 0, -1, -1);         expect_win("t2_clamp", 4000, 0, -1, 1);
        win(10, 1000, -1, -1);      expect_win("zero_cmd", 0, 0, -1, 1);
        win(10, -1000, -1, -1);     expect_win("t3_pre", 1000, 0, -1, 1);
        win(-1, 0, -1, -1);         expect_win("t3_dead", 0, 200, 200, 0);
        win(10, 2000, -1, -1);      expect_win("t3_resume", 1000, 0, -1, 0);
        win(3000, -32768, 100, 3000); expect_win("t5_abort", 0, 101, -1, 0);
        win(-1, 0, -1, -1);         expect_win("t5_rerun", 4000, 0, -1, 0);
        repeat (2000) @(negedge clk);
        check("t6_mid_pulse", int'(bus.pwm_out), 1);
        reset_n = 1'b0;
        @(negedge clk);
        check_reset("t6_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bus.control_signal = 16'sd2500;
        sync(n);
        check("t6_restart_ps", n, 1);
        win(-1, 0, -1, -1);         expect_win("t6_resume", 2500, 0, -1, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_hbridge_driver.md
PWM_HBRIDGE_DRIVER -- requirements
Module: pwm_hbridge_driver

Interface
REQ-001 SHALL have parameter PERIOD, default 5000, meaning clocks per PWM period (20 kHz at 100 MHz).
REQ-002 SHALL have parameter DUTY_MAX, default 4000, meaning magnitude clamp for the duty command in clocks.
REQ-003 SHALL have parameter DEAD_CYCLES, default 200, meaning pwm-off clocks inserted before any direction reversal.
REQ-004 SHALL have port clk  input  1  system clock, 100 MHz; the block uses only this one clock.
REQ-005 SHALL have port reset_n  input  1  reset, synchronous to clk, active-low.
REQ-006 SHALL have port enable  input  1  drive enable; 0 forces the output stage off.
REQ-007 SHALL have port control_signal  input  16 signed  duty command from the position PID; sign is direction, magnitude is on-time in clocks.
REQ-008 SHALL have port pwm_out  output  1  registered H-bridge PWM gate.
REQ-009 SHALL have port dir_out  output  1  registered direction; 1 = forward (command > 0), 0 = reverse.
REQ-010 SHALL have port period_start  output  1  one-clock pulse at each period start, for controller sample alignment.
REQ-011 SHALL have port deadtime_active  output  1  high while the dead-time interval runs.

Function
REQ-012 Period counter SHALL count 0..PERIOD-1 and wrap to 0; period_start SHALL be 1 exactly on the cycle after the counter equals 0 (registered).
REQ-013 On counter == PERIOD-1, control_signal SHALL be sampled into a shadow register; on all other cycles input changes SHALL be ignored.
REQ-014 Sampled magnitude SHALL be |control_signal| clamped to DUTY_MAX; -32768 SHALL yield DUTY_MAX; arithmetic SHALL be 17-bit so no overflow occurs.
REQ-015 Requested direction SHALL be 1 for a command > 0, 0 for a command < 0, and the current dir_out for a command == 0.
REQ-016 Active duty SHALL load from the shadow register only at counter wrap (glitch-free; no mid-period duty change).
REQ-017 In RUN, pwm_out SHALL be 1 one clock after any cycle where counter < active duty; duty 0 SHALL give constant 0.
REQ-018 FSM states SHALL be IDLE, RUN, DEADTIME, RESYNC.
REQ-019 IDLE: pwm_out = 0, dir_out held; enable = 1 SHALL transition to RUN at the next counter wrap.
REQ-020 RUN: at counter wrap, if requested direction differs from dir_out and magnitude > 0, SHALL transition to DEADTIME with pwm_out = 0 from that period onward.
REQ-021 DEADTIME: pwm_out = 0 and deadtime_active = 1 for exactly DEAD_CYCLES clocks; then dir_out SHALL toggle and the FSM SHALL enter RESYNC.
REQ-022 RESYNC: pwm_out = 0 until the next counter wrap, then RUN using the duty sampled for that period.
REQ-023 A sign reversal sampled during DEADTIME or RESYNC SHALL be evaluated again at the RESYNC-to-RUN wrap under REQ-020.
REQ-024 enable = 0 in any state SHALL enter IDLE on the next clock with pwm_out = 0 and dead-time aborted; dir_out SHALL NOT toggle on abort.
REQ-025 The period counter SHALL run independently of enable and FSM state.

Reset
REQ-026 While reset_n = 0 at a clk edge, state SHALL be IDLE, the counter SHALL be 0, and shadow and active duty SHALL be 0.
REQ-027 During reset, outputs SHALL be pwm_out = 0, dir_out = 1, period_start = 0, deadtime_active = 0; reset mid-period or mid-dead-time SHALL discard all progress.

Structure
REQ-028 Package motor_ctrl_pkg SHALL hold the PERIOD, DUTY_MAX, and DEAD_CYCLES defaults and the FSM state enum, shared with the PID controller.
REQ-029 One sub-module, pwm_period_counter (counter, wrap, and period_start), SHALL be instantiated; everything else stays in pwm_hbridge_driver.

Verification
REQ-030 Test 1: enable = 1, control_signal = +2500 -> pwm_out high 2500 of 5000 clocks per period, dir_out = 1, period_start every 5000 clocks.
REQ-031 Test 2: control_signal = +6000 then -32768 -> high time 4000 clocks; the second command gives dir reversal and then 4000 clocks high.
REQ-032 Test 3: +1000 to -1000 -> one period with pwm_out = 0 throughout, deadtime_active high for exactly 200 clocks, dir_out toggles to 0 on the cycle after that, and 1000-clock pulses resume at the next wrap.
REQ-033 Test 4: change control_signal from 1000 to 3000 at counter = 2000 -> the current period stays 1000 clocks high and the next period is 3000.
REQ-034 Test 5: drop enable at dead-time clock 100 -> pwm_out = 0 next clock, dir_out unchanged; re-enable -> RUN at next wrap.
REQ-035 Test 6: assert reset_n = 0 mid-pulse -> all outputs reach reset values at the next clk edge, and the counter restarts at 0 after release.
